// File: rtl/serial_tx_fifo.sv
// Buffered UART transmitter: FIFO of DATA_BITS words feeding a start/data/parity/stop serialiser.
// Latency: word written at edge E into an empty, idle block drives the start bit from edge E+1.
// Backpressure: o_ready = !full (evaluated before any same-cycle pop); writes while full are dropped.

// Small synchronous FIFO: extra pointer MSB distinguishes full from empty.
// Latency: pushed word is visible on pop_dat_o from the next edge; pop is same-edge.
// Backpressure: push ignored when full; pop ignored when empty.
module serial_tx_fifo_buf #(
    parameter int W  = 8,
    parameter int AW = 2
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_vld_i,
    input  logic [W-1:0]  push_dat_i,
    input  logic          pop_i,
    output logic [W-1:0]  pop_dat_o,
    output logic [AW:0]   count_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam int          DEPTH   = 1 << AW;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic [AW:0]  count;
    logic         push;
    logic         pop;

    // Occupancy is the pointer difference; wrap is implicit in the AW+1 bit arithmetic.
    assign count     = wr_ptr_q - rd_ptr_q;
    assign full_o    = (count == DEPTH_C);
    assign empty_o   = (count == '0);
    assign count_o   = count;
    assign push      = push_vld_i && !full_o;
    assign pop       = pop_i && !empty_o;
    assign pop_dat_o = mem_q[rd_ptr_q[AW-1:0]];

    // Next-state pointers; a push and a pop in the same cycle both advance.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // Pointer registers; reset empties the FIFO and discards anything queued.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
        end
    end

endmodule

// Top: FIFO plus frame serialiser with registered line output.
// Latency: 1 clock from FIFO write (into idle, empty block) to start bit; frames stream back to back.
// Backpressure: o_ready low while FIFO holds 2**FIFO_AW words; the word on the wire is not counted.
module serial_tx_fifo #(
    parameter int CLK_FREQ  = 48_000_000,
    parameter int BAUD_RATE = 115_200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int FIFO_AW   = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_valid,
    input  logic [DATA_BITS-1:0] i_data,
    output logic                 o_ready,
    output logic                 o_busy,
    output logic [FIFO_AW:0]     o_count,
    output logic                 o_tx
);

    localparam int DIV = CLK_FREQ / BAUD_RATE;
    // Baud counter must hold DIV-1; DIV of 2 still needs one bit.
    localparam int BCW = (DIV > 2) ? $clog2(DIV) : 1;

    localparam logic [BCW-1:0] DIV_M1    = BCW'(DIV - 1);
    localparam logic [2:0]     DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0]     STOP_LAST = 3'(STOP_BITS - 1);

    // Refuse to build configurations the serialiser cannot represent.
    if (DIV < 2) begin : g_bad_div
        $error("serial_tx_fifo: CLK_FREQ/BAUD_RATE must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
        $error("serial_tx_fifo: DATA_BITS must be 5..8");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("serial_tx_fifo: PARITY must be 0 (none), 1 (odd) or 2 (even)");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("serial_tx_fifo: STOP_BITS must be 1 or 2");
    end
    if (FIFO_AW < 1 || FIFO_AW > 6) begin : g_bad_fifo_aw
        $error("serial_tx_fifo: FIFO_AW must be 1..6");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                 state_q;
    logic [BCW-1:0]         baud_q;
    logic [2:0]             bit_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic                   par_q;
    logic                   tx_q;

    logic                   fifo_full;
    logic                   fifo_empty;
    logic [FIFO_AW:0]       fifo_count;
    logic [DATA_BITS-1:0]   fifo_dat;
    logic                   pop;
    logic                   baud_zero;
    logic                   stop_done;

    serial_tx_fifo_buf #(
        .W  (DATA_BITS),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk_i      (i_clk),
        .rst_ni     (i_rst_n),
        .push_vld_i (i_valid),
        .push_dat_i (i_data),
        .pop_i      (pop),
        .pop_dat_o  (fifo_dat),
        .count_o    (fifo_count),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    assign baud_zero = (baud_q == '0);
    assign stop_done = (state_q == S_STOP) && baud_zero && (bit_q == STOP_LAST);

    // A word leaves the FIFO when the line is idle, or on the last clock of the
    // final stop bit so the next start bit follows with no idle gap.
    always_comb begin
        pop = 1'b0;
        if (!fifo_empty) begin
            if (state_q == S_IDLE || stop_done) begin
                pop = 1'b1;
            end
        end
    end

    // Frame sequencer: each bit lasts DIV clocks, counted DIV-1 down to 0.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    tx_q <= 1'b1;
                    if (pop) begin
                        shift_q <= fifo_dat;
                        par_q   <= (PARITY == 1) ? ~^fifo_dat : ^fifo_dat;
                        baud_q  <= DIV_M1;
                        bit_q   <= '0;
                        tx_q    <= 1'b0;
                        state_q <= S_START;
                    end
                end
                S_START: begin
                    if (baud_zero) begin
                        baud_q  <= DIV_M1;
                        bit_q   <= '0;
                        tx_q    <= shift_q[0];
                        shift_q <= shift_q >> 1;
                        state_q <= S_DATA;
                    end else begin
                        baud_q <= baud_q - 1'b1;
                    end
                end
                S_DATA: begin
                    if (baud_zero) begin
                        baud_q <= DIV_M1;
                        if (bit_q == DATA_LAST) begin
                            bit_q <= '0;
                            if (PARITY != 0) begin
                                tx_q    <= par_q;
                                state_q <= S_PARITY;
                            end else begin
                                tx_q    <= 1'b1;
                                state_q <= S_STOP;
                            end
                        end else begin
                            bit_q   <= bit_q + 3'd1;
                            tx_q    <= shift_q[0];
                            shift_q <= shift_q >> 1;
                        end
                    end else begin
                        baud_q <= baud_q - 1'b1;
                    end
                end
                S_PARITY: begin
                    if (baud_zero) begin
                        baud_q  <= DIV_M1;
                        bit_q   <= '0;
                        tx_q    <= 1'b1;
                        state_q <= S_STOP;
                    end else begin
                        baud_q <= baud_q - 1'b1;
                    end
                end
                S_STOP: begin
                    if (baud_zero) begin
                        if (bit_q == STOP_LAST) begin
                            bit_q <= '0;
                            if (pop) begin
                                shift_q <= fifo_dat;
                                par_q   <= (PARITY == 1) ? ~^fifo_dat : ^fifo_dat;
                                baud_q  <= DIV_M1;
                                tx_q    <= 1'b0;
                                state_q <= S_START;
                            end else begin
                                baud_q  <= '0;
                                tx_q    <= 1'b1;
                                state_q <= S_IDLE;
                            end
                        end else begin
                            bit_q  <= bit_q + 3'd1;
                            baud_q <= DIV_M1;
                            tx_q   <= 1'b1;
                        end
                    end else begin
                        baud_q <= baud_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    baud_q  <= '0;
                    bit_q   <= '0;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

    assign o_tx    = tx_q;
    assign o_ready = !fifo_full;
    assign o_count = fifo_count;
    assign o_busy  = (state_q != S_IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_serial_tx_fifo.sv
module tb_serial_tx_fifo;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] valid_v = 4'b0000;
    logic [7:0] data_v  = 8'h00;
    wire  [3:0] tx_v;
    wire  [3:0] busy_v;
    wire  [3:0] ready_v;
    wire  [2:0] cnt0, cnt1, cnt2, cnt3;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // 0: 8N1 (main, scoreboarded), 1: 8E2, 2: 8O1, 3: 7E1; all DIV=4, FIFO_AW=2
    serial_tx_fifo #(.CLK_FREQ(500_000), .BAUD_RATE(115_200), .DATA_BITS(8),
                     .PARITY(0), .STOP_BITS(1), .FIFO_AW(2)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid_v[0]), .i_data(data_v),
        .o_ready(ready_v[0]), .o_busy(busy_v[0]), .o_count(cnt0), .o_tx(tx_v[0]));

    serial_tx_fifo #(.CLK_FREQ(500_000), .BAUD_RATE(115_200), .DATA_BITS(8),
                     .PARITY(2), .STOP_BITS(2), .FIFO_AW(2)) u_dut_8e2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid_v[1]), .i_data(data_v),
        .o_ready(ready_v[1]), .o_busy(busy_v[1]), .o_count(cnt1), .o_tx(tx_v[1]));

    serial_tx_fifo #(.CLK_FREQ(500_000), .BAUD_RATE(115_200), .DATA_BITS(8),
                     .PARITY(1), .STOP_BITS(1), .FIFO_AW(2)) u_dut_8o1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid_v[2]), .i_data(data_v),
        .o_ready(ready_v[2]), .o_busy(busy_v[2]), .o_count(cnt2), .o_tx(tx_v[2]));

    serial_tx_fifo #(.CLK_FREQ(500_000), .BAUD_RATE(115_200), .DATA_BITS(7),
                     .PARITY(2), .STOP_BITS(1), .FIFO_AW(2)) u_dut_7e1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid_v[3]), .i_data(data_v[6:0]),
        .o_ready(ready_v[3]), .o_busy(busy_v[3]), .o_count(cnt3), .o_tx(tx_v[3]));

    // Scoreboard for the 8N1 instance: words queued when accepted, popped at start bit.
    logic [7:0]  exp_q[$];
    int          mon_pos     = -1;
    int          mon_frames  = 0;
    int          mon_idle    = 0;
    int          mon_gap_max = 0;
    int          mon_cnt_max = 0;
    bit          mon_gap_arm = 1'b0;
    logic [39:0] mon_act;
    logic [39:0] mon_exp;
    logic [7:0]  mon_d;

    // Line monitor: captures 40 samples per frame (4 per bit) and compares whole frame.
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mon_pos     = -1;
            mon_idle    = 0;
            mon_gap_arm = 1'b0;
            exp_q.delete();
        end else begin
            if (int'(cnt0) > mon_cnt_max) mon_cnt_max = int'(cnt0);
            if (mon_pos < 0) begin
                if (tx_v[0] === 1'b0) begin
                    if (exp_q.size() == 0) begin
                        mon_exp = '1;
                    end else begin
                        mon_d = exp_q.pop_front();
                        for (int i = 0; i < 40; i++) begin
                            if (i < 4)        mon_exp[i] = 1'b0;
                            else if (i >= 36) mon_exp[i] = 1'b1;
                            else              mon_exp[i] = mon_d[(i / 4) - 1];
                        end
                    end
                    if (mon_gap_arm && mon_idle > mon_gap_max) mon_gap_max = mon_idle;
                    mon_act = '0;
                    mon_pos = 0;
                end else begin
                    mon_idle++;
                end
            end
            if (mon_pos >= 0) begin
                mon_act[mon_pos] = tx_v[0];
                mon_pos++;
                if (mon_pos == 40) begin
                    checks++;
                    if (mon_act !== mon_exp) begin
                        errors++;
                        $display("FAIL frame_8n1: line samples %h, required %h", mon_act, mon_exp);
                    end
                    mon_frames++;
                    mon_pos     = -1;
                    mon_idle    = 0;
                    mon_gap_arm = 1'b1;
                end
            end
        end
    end

    function automatic logic [2:0] cnt_of(input int k);
        case (k)
            0:       return cnt0;
            1:       return cnt1;
            2:       return cnt2;
            default: return cnt3;
        endcase
    endfunction

    // Offer one word to the 8N1 instance; i_valid is left high for streaming.
    task automatic push_word(input logic [7:0] d);
        int n;
        @(negedge clk);
        valid_v[0] = 1'b1;
        data_v     = d;
        n          = 0;
        while (ready_v[0] !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (ready_v[0] !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: o_ready=%b, required 1 within 200 clocks", ready_v[0]);
        end else begin
            exp_q.push_back(d);
        end
        @(posedge clk);
    endtask

    task automatic release_valid();
        @(negedge clk);
        valid_v[0] = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n;
        n = 0;
        @(negedge clk);
        while ((busy_v[0] !== 1'b0 || mon_pos >= 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy_v[0] !== 1'b0 || mon_pos >= 0) begin
            errors++;
            $display("FAIL %s_drain: o_busy=%b after %0d clocks, required 0", name, busy_v[0], budget);
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({tx_v[0], ready_v[0], busy_v[0], cnt0} !== {3'b110, 3'd0}) begin
            errors++;
            $display("FAIL reset_state: tx/ready/busy/count=%b/%b/%b/%0d, required 1/1/0/0",
                     tx_v[0], ready_v[0], busy_v[0], cnt0);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_8n1();
        int n;
        int ones;
        int f0;
        f0 = mon_frames;
        push_word(8'h4B);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) valid_v[0] = 1'b0;
        end while (tx_v[0] !== 1'b0 && n < 20);
        checks++;
        if (n != 2) begin
            errors++;
            $display("FAIL start_latency: start bit seen %0d negedges after write edge, required 2", n);
        end
        ones = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy_v[0] === 1'b1) ones++;
            @(negedge clk);
        end
        checks++;
        if (ones != 40) begin
            errors++;
            $display("FAIL busy_8n1: o_busy high %0d of 40 frame clocks, required 40", ones);
        end
        checks++;
        if ({busy_v[0], tx_v[0]} !== 2'b01) begin
            errors++;
            $display("FAIL idle_after_8n1: busy/tx=%b/%b, required 0/1", busy_v[0], tx_v[0]);
        end
        checks++;
        if (mon_frames - f0 != 1) begin
            errors++;
            $display("FAIL frames_8n1: %0d frames, required 1", mon_frames - f0);
        end
    endtask

    task automatic check_other(input int k, input logic [7:0] d, input logic [11:0] expv,
                               input int nbits, input string name);
        int n;
        int bad;
        int first_bad;
        logic [2:0] cntk;
        @(negedge clk);
        valid_v[k] = 1'b1;
        data_v     = d;
        @(posedge clk);
        @(negedge clk);
        valid_v[k] = 1'b0;
        n = 0;
        while (tx_v[k] !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        bad       = 0;
        first_bad = -1;
        for (int i = 0; i < nbits * 4; i++) begin
            if (tx_v[k] !== expv[i / 4] || busy_v[k] !== 1'b1) begin
                bad++;
                if (first_bad < 0) first_bad = i;
            end
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s_frame: %0d bad samples, first at clock %0d, required bits %b (LSB first)",
                     name, bad, first_bad, expv);
        end
        cntk = cnt_of(k);
        checks++;
        if ({tx_v[k], busy_v[k], ready_v[k], cntk} !== {3'b101, 3'd0}) begin
            errors++;
            $display("FAIL %s_end: tx/busy/ready/count=%b/%b/%b/%0d, required 1/0/1/0",
                     name, tx_v[k], busy_v[k], ready_v[k], cntk);
        end
    endtask

    task automatic test_parity();
        check_other(1, 8'h4B, 12'b1100_1001_0110, 12, "8e2");
        check_other(2, 8'h4B, 12'b0110_1001_0110, 11, "8o1");
        check_other(3, 8'h7F, 12'b0011_1111_1110, 10, "7e1");
    endtask

    task automatic test_streaming();
        int f0;
        wait_idle(100, "pre_stream");
        f0          = mon_frames;
        mon_gap_arm = 1'b0;
        mon_gap_max = 0;
        for (int i = 0; i < 6; i++) begin
            push_word(8'(8'h41 + i));
            if (i == 4) begin
                #1;
                checks++;
                if ({ready_v[0], cnt0} !== {1'b0, 3'd4}) begin
                    errors++;
                    $display("FAIL stream_full: ready/count=%b/%0d, required 0/4", ready_v[0], cnt0);
                end
            end
        end
        release_valid();
        wait_idle(600, "stream");
        checks++;
        if (mon_frames - f0 != 6) begin
            errors++;
            $display("FAIL stream_frames: %0d frames, required 6", mon_frames - f0);
        end
        checks++;
        if (mon_gap_max != 0) begin
            errors++;
            $display("FAIL stream_gap: max idle between frames %0d clocks, required 0", mon_gap_max);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL stream_left: %0d words not transmitted, required 0", exp_q.size());
        end
    endtask

    task automatic test_full_pop();
        int n;
        logic [2:0] prev;
        for (int i = 0; i < 5; i++) push_word(8'(8'h61 + i));
        @(negedge clk);
        valid_v[0] = 1'b1;
        data_v     = 8'h66;
        prev       = cnt0;
        n          = 0;
        while (ready_v[0] !== 1'b1 && n < 100) begin
            prev = cnt0;
            @(negedge clk);
            n++;
        end
        checks++;
        if ({prev, cnt0} !== {3'd4, 3'd3}) begin
            errors++;
            $display("FAIL full_pop: count %0d -> %0d at pop edge, required 4 -> 3", prev, cnt0);
        end
        exp_q.push_back(8'h66);
        @(posedge clk);
        @(negedge clk);
        valid_v[0] = 1'b0;
        checks++;
        if (cnt0 !== 3'd4) begin
            errors++;
            $display("FAIL full_refill: count=%0d, required 4", cnt0);
        end
        wait_idle(600, "full_pop");
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL full_pop_left: %0d words not transmitted, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset_midframe();
        int n;
        int f0;
        push_word(8'hA5);
        push_word(8'h3C);
        release_valid();
        n = 0;
        while (tx_v[0] !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        repeat (17) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({tx_v[0], busy_v[0], ready_v[0], cnt0} !== {3'b101, 3'd0}) begin
            errors++;
            $display("FAIL midframe_reset: tx/busy/ready/count=%b/%b/%b/%0d, required 1/0/1/0",
                     tx_v[0], busy_v[0], ready_v[0], cnt0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        f0 = mon_frames;
        push_word(8'h55);
        release_valid();
        wait_idle(200, "post_reset");
        checks++;
        if (mon_frames - f0 != 1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL post_reset_frames: %0d frames, %0d pending, required 1 and 0",
                     mon_frames - f0, exp_q.size());
        end
    endtask

    task automatic test_wrap();
        int f0;
        f0 = mon_frames;
        for (int i = 0; i < 20; i++) begin
            push_word(8'($urandom_range(0, 255)));
            release_valid();
            wait_idle(200, "wrap");
        end
        checks++;
        if (mon_frames - f0 != 20 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL wrap_frames: %0d frames, %0d pending, required 20 and 0",
                     mon_frames - f0, exp_q.size());
        end
        checks++;
        if (mon_cnt_max > 4) begin
            errors++;
            $display("FAIL count_max: o_count reached %0d, required at most 4", mon_cnt_max);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_streaming();
        test_full_pop();
        test_reset_midframe();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
